// File: rtl/xc_aessub_seq.sv
// Byte-serial AES SubWord unit. One shared S-box lookup (forward or inverse) handles
// four bytes over four BUSY cycles. The result is optionally rotated left by 8 bits.
module xc_aessub_seq (
   input  logic        g_clk,
   input  logic        g_resetn,
   input  logic        valid,
   input  logic        flush,
   input  logic [31:0] rs1,
   input  logic [31:0] rs2,
   input  logic        enc,
   input  logic        rot,
   output logic        ready,
   output logic [31:0] result
);

   // Tables are written in natural order, so entry 0 is the most significant byte.
   localparam logic [2047:0] SBOX_FWD = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

   localparam logic [2047:0] SBOX_INV = {
      128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
      128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
      128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
      128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
      128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
      128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
      128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
      128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d};

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_nextState;
   logic [1:0]  r_cnt;
   logic [31:0] r_bytes;
   logic        r_enc;
   logic        r_rot;
   logic [31:0] r_result;
   logic        w_accept;
   logic [7:0]  w_byteIn;
   logic [7:0]  w_sboxFwd;
   logic [7:0]  w_sboxInv;
   logic [7:0]  w_sbox;
   logic [31:0] w_merged;
   logic [31:0] w_final;
   logic        w_unused;

   // Only the interleaved byte lanes of rs1/rs2 feed the lookup.
   assign w_unused  = ^{rs1[31:24], rs1[15:8], rs2[23:16], rs2[7:0]};

   assign w_accept  = (r_state == IDLE) && valid && !flush;
   assign w_byteIn  = r_bytes[{r_cnt, 3'b000} +: 8];
   assign w_sboxFwd = SBOX_FWD[{~w_byteIn, 3'b000} +: 8];
   assign w_sboxInv = SBOX_INV[{~w_byteIn, 3'b000} +: 8];
   assign w_sbox    = r_enc ? w_sboxFwd : w_sboxInv;
   assign result    = r_result;

   always_comb begin
      w_merged = r_result;
      w_merged[{r_cnt, 3'b000} +: 8] = w_sbox;
      w_final = w_merged;
      if ((r_cnt == 2'd3) && r_rot) begin
         w_final = {w_merged[23:0], w_merged[31:24]};
      end
   end

   always_comb begin
      w_nextState = r_state;
      ready       = 1'b0;
      case (r_state)
         IDLE: if (w_accept) w_nextState = BUSY;
         BUSY: if (r_cnt == 2'd3) w_nextState = DONE;
         DONE: begin
            ready       = 1'b1;
            w_nextState = IDLE;
         end
         default: w_nextState = IDLE;
      endcase
      if (flush) begin
         w_nextState = IDLE;
      end
   end

   always_ff @(posedge g_clk or negedge g_resetn) begin
      if (!g_resetn) begin
         r_state  <= IDLE;
         r_cnt    <= 2'd0;
         r_bytes  <= 32'h0;
         r_enc    <= 1'b0;
         r_rot    <= 1'b0;
         r_result <= 32'h0;
      end else begin
         r_state <= w_nextState;
         if (w_accept) begin
            r_bytes <= {rs2[31:24], rs1[23:16], rs2[15:8], rs1[7:0]};
            r_enc   <= enc;
            r_rot   <= rot;
            r_cnt   <= 2'd0;
         end else if ((r_state == BUSY) && !flush) begin
            r_result <= w_final;
            r_cnt    <= r_cnt + 2'd1;
         end
      end
   end

endmodule
